fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath, instantiated directly inside `Top_Level_1` ahead of the decode stage. It owns the program counter and drives the instruction-memory address. It latches the fetched word into the IF/ID pipeline register. It applies stall, flush and branch/jump redirects from later stages, and stops fetching on a halt word.

---
 rtl/mips_pkg.sv | 8 +
 rtl/ifid_reg.sv | 27 ++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM encodings and instruction constants.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP           = '0;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HALT} state_t;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; reset/clear beat hold, hold beats load.
module ifid_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               clr,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr,
  input  logic [31:0]        pc_plus4,
  output logic [INSTR_W-1:0] instr_q,
  output logic [31:0]        pc_plus4_q,
  output logic               valid
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      instr_q    <= NOP;
      pc_plus4_q <= '0;
      valid      <= 1'b0;
    end else if (load && !hold) begin
      instr_q    <= instr;
      pc_plus4_q <= pc_plus4;
      valid      <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, fetch FSM, redirect/stall/flush handling, IF/ID latch.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               BranchTaken,
  input  logic [31:0]        BranchTarget,
  input  logic               Jump,
  input  logic [31:0]        JumpTarget,
  output logic [31:0]        ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] IFID_Instr,
  output logic [31:0]        IFID_PCPlus4,
  output logic               IFID_Valid,
  output logic               Halted,
  output logic               AlignErr,
  output logic [31:0]        FetchCount
);
  state_t      state;
  logic [31:0] pc;
  logic        redirect, in_fetch, in_halt, is_halt;
  logic        ifid_clr, ifid_load, ifid_hold;
  logic [31:0] target, pc_plus4;

  assign ImemAddr = pc;
  assign pc_plus4 = pc + 32'd4;
  // Branch belongs to the older instruction, so it beats a jump in the same cycle.
  assign redirect = BranchTaken | Jump;
  assign target   = BranchTaken ? BranchTarget : JumpTarget;
  assign is_halt  = (ImemData == HALT_WORD);
  assign in_fetch = (state == S_FETCH);
  assign in_halt  = (state == S_HALT);

  assign ifid_clr  = (in_fetch && (redirect || Flush)) || in_halt;
  assign ifid_hold = in_fetch && Stall;
  assign ifid_load = in_fetch && !redirect && !Flush;

  ifid_reg u_ifid (
    .clk        (Clk),
    .rst        (Rst),
    .hold       (ifid_hold),
    .clr        (ifid_clr),
    .load       (ifid_load),
    .instr      (ImemData),
    .pc_plus4   (pc_plus4),
    .instr_q    (IFID_Instr),
    .pc_plus4_q (IFID_PCPlus4),
    .valid      (IFID_Valid)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      Halted     <= 1'b0;
      AlignErr   <= 1'b0;
      FetchCount <= '0;
    end else begin
      AlignErr <= 1'b0;
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (redirect) begin
            pc       <= {target[31:2], 2'b00};
            AlignErr <= |target[1:0];
          end else if (Flush) begin
            if (!Stall) pc <= pc_plus4;
          end else if (!Stall) begin
            FetchCount <= FetchCount + 32'd1;
            // The halt word is latched, but the PC stays on it.
            if (is_halt) begin
              state  <= S_HALT;
              Halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        S_HALT: begin
          if (redirect) begin
            pc       <= {target[31:2], 2'b00};
            AlignErr <= |target[1:0];
            Halted   <= 1'b0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues expected post-edge outputs, monitor compares.
module tb_fetch_stage;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        halted;
    logic        aerr;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11, stall = '0, flush = '0, br = '0, jmp = '0;
  logic [31:0] bt [2], jt [2], dat [2];
  logic [31:0] addr [2], instr [2], pcp4 [2], cnt [2];
  logic [1:0]  valid, halted, aerr;
  logic        halt_en = 1'b0;
  exp_t        qa [$], qb [$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory: word at address a is 0x20080001 + a/4, optional halt word at 0x10.
  assign dat[0] = (halt_en && addr[0] == 32'h10) ? 32'hFFFF_FFFF : 32'h2008_0001 + (addr[0] >> 2);
  assign dat[1] = 32'h2008_0001 + (addr[1] >> 2);

  fetch_stage u_a (
    .Clk(clk), .Rst(rst[0]), .Stall(stall[0]), .Flush(flush[0]),
    .BranchTaken(br[0]), .BranchTarget(bt[0]), .Jump(jmp[0]), .JumpTarget(jt[0]),
    .ImemAddr(addr[0]), .ImemData(dat[0]), .IFID_Instr(instr[0]), .IFID_PCPlus4(pcp4[0]),
    .IFID_Valid(valid[0]), .Halted(halted[0]), .AlignErr(aerr[0]), .FetchCount(cnt[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_b (
    .Clk(clk), .Rst(rst[1]), .Stall(stall[1]), .Flush(flush[1]),
    .BranchTaken(br[1]), .BranchTarget(bt[1]), .Jump(jmp[1]), .JumpTarget(jt[1]),
    .ImemAddr(addr[1]), .ImemData(dat[1]), .IFID_Instr(instr[1]), .IFID_PCPlus4(pcp4[1]),
    .IFID_Valid(valid[1]), .Halted(halted[1]), .AlignErr(aerr[1]), .FetchCount(cnt[1])
  );

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2);
  endfunction

  function automatic exp_t mk(input logic [31:0] a, i, p, input logic v, h, e, input logic [31:0] c);
    exp_t x;
    x.addr = a; x.instr = i; x.pcp4 = p; x.valid = v; x.halted = h; x.aerr = e; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] got, want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, d, $time, got, want);
    end
  endtask

  task automatic cmp(input int d, input exp_t e);
    chk("ImemAddr", d, addr[d], e.addr);
    chk("IFID_Instr", d, instr[d], e.instr);
    chk("IFID_PCPlus4", d, pcp4[d], e.pcp4);
    chk("IFID_Valid", d, {31'd0, valid[d]}, {31'd0, e.valid});
    chk("Halted", d, {31'd0, halted[d]}, {31'd0, e.halted});
    chk("AlignErr", d, {31'd0, aerr[d]}, {31'd0, e.aerr});
    chk("FetchCount", d, cnt[d], e.cnt);
  endtask

  // One cycle: drive inputs for dut d and queue the outputs expected after the next edge.
  task automatic cyc(input int d, input logic r, s, f, b, input logic [31:0] btv,
                     input logic j, input logic [31:0] jtv, input exp_t e);
    @(negedge clk);
    rst[d] = r; stall[d] = s; flush[d] = f; br[d] = b; bt[d] = btv; jmp[d] = j; jt[d] = jtv;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin e = qa.pop_front(); cmp(0, e); end
    if (qb.size() > 0) begin e = qb.pop_front(); cmp(1, e); end
  end

  initial begin
    bt[0] = '0; bt[1] = '0; jt[0] = '0; jt[1] = '0;
    // Reset and straight-line fetch, with a 2-cycle stall at PC=8
    cyc(0, 1,0,0,0,0,0,0, mk(0, 0, 0, 0,0,0, 0));
    cyc(0, 1,0,0,0,0,0,0, mk(0, 0, 0, 0,0,0, 0));
    cyc(0, 0,0,0,1,32'h40,1,32'h80, mk(0, 0, 0, 0,0,0, 0));  // S_RESET ignores inputs
    cyc(0, 0,0,0,0,0,0,0, mk(4, ins(0), 4, 1,0,0, 1));
    cyc(0, 0,0,0,0,0,0,0, mk(8, ins(4), 8, 1,0,0, 2));
    cyc(0, 0,1,0,0,0,0,0, mk(8, ins(4), 8, 1,0,0, 2));
    cyc(0, 0,1,0,0,0,0,0, mk(8, ins(4), 8, 1,0,0, 2));
    cyc(0, 0,0,0,0,0,0,0, mk(12, ins(8), 12, 1,0,0, 3));
    // Branch and jump together: branch wins, one bubble
    cyc(0, 0,1,0,1,32'h40,1,32'h80, mk(32'h40, 0, 0, 0,0,0, 3));
    cyc(0, 0,0,0,0,0,0,0, mk(32'h44, ins(32'h40), 32'h44, 1,0,0, 4));
    // Misaligned jump
    cyc(0, 0,0,0,0,0,1,32'h106, mk(32'h104, 0, 0, 0,0,1, 4));
    cyc(0, 0,0,0,0,0,0,0, mk(32'h108, ins(32'h104), 32'h108, 1,0,0, 5));
    // Flush alone advances PC; flush with stall holds it
    cyc(0, 0,0,1,0,0,0,0, mk(32'h10C, 0, 0, 0,0,0, 5));
    cyc(0, 0,1,1,0,0,0,0, mk(32'h10C, 0, 0, 0,0,0, 5));
    // Halt at 0x10 then wrong-path recovery
    halt_en = 1'b1;
    cyc(0, 0,0,0,0,0,1,32'h10, mk(32'h10, 0, 0, 0,0,0, 5));
    cyc(0, 0,0,0,0,0,0,0, mk(32'h10, 32'hFFFF_FFFF, 32'h14, 1,1,0, 6));
    cyc(0, 0,1,1,0,0,0,0, mk(32'h10, 0, 0, 0,1,0, 6));
    cyc(0, 0,0,0,0,0,0,0, mk(32'h10, 0, 0, 0,1,0, 6));
    cyc(0, 0,0,0,1,32'h8,0,0, mk(32'h8, 0, 0, 0,0,0, 6));
    cyc(0, 0,0,0,0,0,0,0, mk(32'hC, ins(8), 32'hC, 1,0,0, 7));
    cyc(0, 0,0,0,0,0,0,0, mk(32'h10, ins(32'hC), 32'h10, 1,0,0, 8));
    // Reset during stall overrides everything
    cyc(0, 1,1,0,0,0,0,0, mk(0, 0, 0, 0,0,0, 0));

    // Wrapping PC from RESET_PC = 0xFFFF_FFFC
    cyc(1, 1,0,0,0,0,0,0, mk(32'hFFFF_FFFC, 0, 0, 0,0,0, 0));
    cyc(1, 0,0,0,0,0,0,0, mk(32'hFFFF_FFFC, 0, 0, 0,0,0, 0));
    cyc(1, 0,0,0,0,0,0,0, mk(0, ins(32'hFFFF_FFFC), 0, 1,0,0, 1));
    cyc(1, 0,0,0,0,0,0,0, mk(4, ins(0), 4, 1,0,0, 2));
    cyc(1, 0,1,0,0,0,0,0, mk(4, ins(0), 4, 1,0,0, 2));
    cyc(1, 1,1,0,0,0,0,0, mk(32'hFFFF_FFFC, 0, 0, 0,0,0, 0));

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
